// File: rtl/nibble_sched.sv
// nibble_sched: round-robin arbiter for two 32-bit requesters feeding a nibble serializer.
// Define NIBBLE_SCHED_PARITY_EN to add the registered parityOut output.
module nibble_sched #(
  parameter int NIBBLES = 8
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        validA,
  input  logic [31:0] dataA,
  output logic        readyA,
  input  logic        validB,
  input  logic [31:0] dataB,
  output logic        readyB,
  output logic [3:0]  nibbleOut,
  output logic        validOut,
  input  logic        readyOut,
  output logic [2:0]  selA,
  output logic [2:0]  selB,
  output logic        sel,
  output logic        busy
`ifdef NIBBLE_SCHED_PARITY_EN
  ,
  output logic        parityOut
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  state_t      state_reg, state_next;
  logic        pri_a_reg, pri_a_next;   // 1: A holds priority
  logic [2:0]  idx_reg, idx_next;
  logic [2:0]  idx_inc;
  logic [31:0] word_reg, word_next;
  logic        sel_reg, sel_next;
  logic [2:0]  sel_a_reg, sel_a_next;
  logic [2:0]  sel_b_reg, sel_b_next;
  logic [3:0]  nibble_reg, nibble_next;
  logic        valid_reg, valid_next;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pri_a_reg  <= 1'b1;
      idx_reg    <= 3'd0;
      word_reg   <= 32'd0;
      sel_reg    <= 1'b0;
      sel_a_reg  <= 3'd0;
      sel_b_reg  <= 3'd0;
      nibble_reg <= 4'd0;
      valid_reg  <= 1'b0;
    end else begin
      pri_a_reg  <= pri_a_next;
      idx_reg    <= idx_next;
      word_reg   <= word_next;
      sel_reg    <= sel_next;
      sel_a_reg  <= sel_a_next;
      sel_b_reg  <= sel_b_next;
      nibble_reg <= nibble_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pri_a_next  = pri_a_reg;
    idx_next    = idx_reg;
    word_next   = word_reg;
    sel_next    = sel_reg;
    sel_a_next  = sel_a_reg;
    sel_b_next  = sel_b_reg;
    nibble_next = nibble_reg;
    valid_next  = valid_reg;
    readyA      = 1'b0;
    readyB      = 1'b0;
    idx_inc     = idx_reg + 3'd1;

    case (state_reg)
      IDLE: begin
        readyA = validA & (pri_a_reg | ~validB);
        readyB = validB & (~pri_a_reg | ~validA);
        if (readyA || readyB) begin
          word_next   = readyA ? dataA : dataB;
          sel_next    = readyA;
          idx_next    = 3'd0;
          pri_a_next  = ~pri_a_reg;
          valid_next  = 1'b1;
          nibble_next = readyA ? dataA[3:0] : dataB[3:0];
          state_next  = SEND;
          if (readyA) sel_a_next = 3'd0;
          else        sel_b_next = 3'd0;
        end
      end
      SEND: begin
        // Everything holds while the downstream stalls.
        if (readyOut) begin
          if (idx_reg == LAST) begin
            valid_next = 1'b0;
            state_next = IDLE;
          end else begin
            idx_next    = idx_inc;
            nibble_next = word_reg[{idx_inc, 2'b00} +: 4];
            if (sel_reg) sel_a_next = idx_inc;
            else         sel_b_next = idx_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign nibbleOut = nibble_reg;
  assign validOut  = valid_reg;
  assign selA      = sel_a_reg;
  assign selB      = sel_b_reg;
  assign sel       = sel_reg;
  assign busy      = (state_reg == SEND);

`ifdef NIBBLE_SCHED_PARITY_EN
  logic parity_reg;

  // Tracks nibble_next so parity changes on exactly the same edge as the nibble.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= ^nibble_next;
    end
  end

  assign parityOut = parity_reg;
`endif

endmodule

// File: tb/tb_nibble_sched.sv
// Directed bench for nibble_sched: default 8-nibble instance plus a 2-nibble instance.
module tb_nibble_sched;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;

  logic        validA = 1'b0, validB = 1'b0, readyOut = 1'b0;
  logic [31:0] dataA = 32'd0, dataB = 32'd0;
  logic        readyA, readyB, validOut, sel, busy;
  logic [3:0]  nibbleOut;
  logic [2:0]  selA, selB;

  logic        validA2 = 1'b0, readyOut2 = 1'b1;
  logic [31:0] dataA2 = 32'd0;
  logic        validB2 = 1'b0;
  logic [31:0] dataB2 = 32'd0;
  logic        readyA2, readyB2, validOut2, sel2, busy2;
  logic [3:0]  nibbleOut2;
  logic [2:0]  selA2, selB2;

`ifdef NIBBLE_SCHED_PARITY_EN
  logic        parity1, parity2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_sched #(.NIBBLES(8)) dut (
    .clk(clk), .reset_L(reset_L),
    .validA(validA), .dataA(dataA), .readyA(readyA),
    .validB(validB), .dataB(dataB), .readyB(readyB),
    .nibbleOut(nibbleOut), .validOut(validOut), .readyOut(readyOut),
    .selA(selA), .selB(selB), .sel(sel), .busy(busy)
`ifdef NIBBLE_SCHED_PARITY_EN
    , .parityOut(parity1)
`endif
  );

  nibble_sched #(.NIBBLES(2)) dut2 (
    .clk(clk), .reset_L(reset_L),
    .validA(validA2), .dataA(dataA2), .readyA(readyA2),
    .validB(validB2), .dataB(dataB2), .readyB(readyB2),
    .nibbleOut(nibbleOut2), .validOut(validOut2), .readyOut(readyOut2),
    .selA(selA2), .selB(selB2), .sel(sel2), .busy(busy2)
`ifdef NIBBLE_SCHED_PARITY_EN
    , .parityOut(parity2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_a1 [8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
  logic [3:0] exp_p  [8] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    // Reset state
    #1;
    check("rst_nibble", nibbleOut, 4'h0);
    check("rst_valid", validOut, 1'b0);
    check("rst_selA", selA, 3'd0);
    check("rst_selB", selB, 3'd0);
    check("rst_sel", sel, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {readyA, readyB}, 2'b00);
    #11 reset_L = 1'b1;

    // Single A word with readyOut held high
    tick();
    dataA = 32'h89ABCDEF; validA = 1'b1; readyOut = 1'b1;
    #1 check("a1_readyA", readyA, 1'b1);
    tick();
    validA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("a1_nib%0d", i), nibbleOut, exp_a1[i]);
      check($sformatf("a1_selA%0d", i), selA, i);
      check($sformatf("a1_sv%0d", i), {sel, validOut, busy, readyA}, 4'b1110);
      tick();
    end
    check("a1_done_valid", validOut, 1'b0);
    check("a1_done_busy", busy, 1'b0);

    // Contention from reset: A, B, A, B with a one-cycle gap
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    dataA = 32'h11111111; dataB = 32'h22222222;
    validA = 1'b1; validB = 1'b1;
    for (int w = 0; w < 4; w++) begin
      #1;
      check($sformatf("ct_w%0d_readyA", w), readyA, (w % 2 == 0));
      check($sformatf("ct_w%0d_readyB", w), readyB, (w % 2 == 1));
      check($sformatf("ct_w%0d_gap", w), validOut, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
        check($sformatf("ct_w%0d_n%0d", w, i), nibbleOut, (w % 2 == 0) ? 4'h1 : 4'h2);
        check($sformatf("ct_w%0d_s%0d", w, i), {sel, validOut, readyA, readyB},
              {(w % 2 == 0), 3'b100});
        tick();
      end
    end
    validA = 1'b0; validB = 1'b0;

    // Backpressure on a B word, readyOut alternating 0/1
    dataB = 32'h76543210; validB = 1'b1;
    #1 check("bp_readyB", readyB, 1'b1);
    tick();
    validB = 1'b0;
    for (int k = 0; k < 8; k++) begin
      readyOut = 1'b0;
      tick();
      check($sformatf("bp_hold_n%0d", k), nibbleOut, k);
      check($sformatf("bp_hold_selB%0d", k), selB, k);
      check($sformatf("bp_selA_hold%0d", k), {sel, selA, validOut}, {1'b0, 3'd7, 1'b1});
      readyOut = 1'b1;
      #1 check($sformatf("bp_n%0d", k), nibbleOut, k);
      tick();
    end
    check("bp_done", validOut, 1'b0);

    // Asynchronous reset in the middle of a word
    dataA = 32'hDEADBEEF; validA = 1'b1;
    tick();
    validA = 1'b0;
    check("mr_n0", nibbleOut, 4'hF);
    tick(); tick(); tick();
    check("mr_n3", nibbleOut, 4'hB);
    check("mr_selA3", selA, 3'd3);
    #2 reset_L = 1'b0;
    #1;
    check("mr_nibble", nibbleOut, 4'h0);
    check("mr_flags", {validOut, sel, busy, readyA, readyB}, 5'b0);
    check("mr_sels", {selA, selB}, 6'd0);
    @(negedge clk) reset_L = 1'b1;
    @(posedge clk); #1;
    dataA = 32'h11111111; dataB = 32'h22222222;
    validA = 1'b1; validB = 1'b1;
    #1 check("mr_pri", {readyA, readyB}, 2'b10);
    tick();
    validA = 1'b0; validB = 1'b0;
    check("mr_grant", {sel, nibbleOut}, {1'b1, 4'h1});
    repeat (8) tick();
    check("mr_end", validOut, 1'b0);

    // Two-nibble instance, A held valid: one word every 3 cycles
    dataA2 = 32'h000000A5; validA2 = 1'b1;
    #1 check("n2_ready0", readyA2, 1'b1);
    tick();
    check("n2_n0", {validOut2, nibbleOut2, selA2}, {1'b1, 4'h5, 3'd0});
    tick();
    check("n2_n1", {validOut2, nibbleOut2, selA2}, {1'b1, 4'hA, 3'd1});
    check("n2_noready", readyA2, 1'b0);
    tick();
    check("n2_gap", {validOut2, busy2, readyA2}, 3'b001);
    tick();
    check("n2_next", {validOut2, nibbleOut2}, {1'b1, 4'h5});
    validA2 = 1'b0;

`ifdef NIBBLE_SCHED_PARITY_EN
    // Parity follows nibbleOut of 32'h0000F731
    dataA = 32'h0000F731; validA = 1'b1; readyOut = 1'b1;
    tick();
    validA = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("par%0d", i), parity1, exp_p[i]);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
